// File: rtl/dpll_lock_detect.sv
// rtl/dpll_lock_detect.sv - DPLL lock detector: period measurement, comparison, lock and reference-loss tracking
`timescale 1ns/1ps
module dpll_lock_detect #(
    parameter int PERIOD_W   = 16,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_fin,
    input  logic                clk_fout,
    output logic                locked,
    output logic                fin_lost,
    output logic                period_valid,
    output logic [PERIOD_W-1:0] fin_period,
    output logic [PERIOD_W-1:0] fout_period
);
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [PERIOD_W-1:0] CNT_MAX     = '1;
    localparam logic [PERIOD_W-1:0] CNT_PRE     = {{(PERIOD_W-1){1'b1}}, 1'b0};
    localparam logic [PERIOD_W-1:0] CNT_ONE     = PERIOD_W'(1);
    localparam logic [PERIOD_W:0]   TOL_V       = (PERIOD_W+1)'(TOL);
    localparam logic [7:0]          LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0]          UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

    logic [2:0]          fin_sync;
    logic [2:0]          fout_sync;
    logic                fin_rise;
    logic                fout_rise;
    logic [PERIOD_W-1:0] fin_cnt;
    logic [PERIOD_W-1:0] fout_cnt;
    logic                fin_seen;
    logic                fout_seen;
    logic                fout_ok;
    logic                fin_hit;
    logic                fout_hit;
    logic                cmp_req;
    logic [PERIOD_W:0]   diff;
    logic [PERIOD_W:0]   abs_diff;
    logic                good;
    state_t              state_q;
    state_t              state_d;
    logic [7:0]          good_cnt;
    logic [7:0]          good_d;
    logic [7:0]          bad_cnt;
    logic [7:0]          bad_d;

    // Both inputs get the same 3-flop chain so their rise pulses keep equal latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fin_sync  <= '0;
            fout_sync <= '0;
        end else begin
            fin_sync  <= {fin_sync[1:0], clk_fin};
            fout_sync <= {fout_sync[1:0], clk_fout};
        end
    end

    assign fin_rise  = fin_sync[1] & ~fin_sync[2];
    assign fout_rise = fout_sync[1] & ~fout_sync[2];
    assign fin_hit   = ~fin_rise & (fin_cnt == CNT_PRE);
    assign fout_hit  = ~fout_rise & (fout_cnt == CNT_PRE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fin_cnt    <= '0;
            fin_seen   <= 1'b0;
            fin_lost   <= 1'b0;
            fin_period <= '0;
            cmp_req    <= 1'b0;
        end else begin
            cmp_req <= fin_rise & fin_seen;
            if (fin_rise) begin
                fin_cnt  <= CNT_ONE;
                fin_seen <= 1'b1;
                fin_lost <= 1'b0;
                if (fin_seen) begin
                    fin_period <= fin_cnt;
                end
            end else if (fin_cnt != CNT_MAX) begin
                fin_cnt <= fin_cnt + CNT_ONE;
                if (fin_hit) begin
                    fin_lost <= 1'b1;
                    fin_seen <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fout_cnt    <= '0;
            fout_seen   <= 1'b0;
            fout_ok     <= 1'b0;
            fout_period <= '0;
        end else begin
            if (fout_rise) begin
                fout_cnt  <= CNT_ONE;
                fout_seen <= 1'b1;
                if (fout_seen) begin
                    fout_period <= fout_cnt;
                end
            end else if (fout_cnt != CNT_MAX) begin
                fout_cnt <= fout_cnt + CNT_ONE;
            end
            if (fout_hit) begin
                fout_seen <= 1'b0;
            end
            // A stalled output or a lost reference both invalidate the held fout period.
            if (fin_hit || fout_hit) begin
                fout_ok <= 1'b0;
            end else if (fout_rise && fout_seen) begin
                fout_ok <= 1'b1;
            end
        end
    end

    // Comparison runs the cycle after capture, so a same-edge fout capture is already visible.
    always_comb begin
        diff     = {1'b0, fin_period} - {1'b0, fout_period};
        abs_diff = diff[PERIOD_W] ? -diff : diff;
        good     = fout_ok && (fin_period != CNT_MAX) && (fout_period != CNT_MAX)
                   && (abs_diff <= TOL_V);
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_cnt;
        bad_d   = bad_cnt;
        if (fin_hit) begin
            state_d = UNLOCKED;
            good_d  = '0;
            bad_d   = '0;
        end else if (cmp_req) begin
            if (state_q == UNLOCKED) begin
                if (!good) begin
                    good_d = '0;
                end else if (good_cnt == LOCK_LAST) begin
                    state_d = LOCKED;
                    good_d  = '0;
                    bad_d   = '0;
                end else begin
                    good_d = good_cnt + 8'd1;
                end
            end else begin
                if (good) begin
                    bad_d = '0;
                end else if (bad_cnt == UNLOCK_LAST) begin
                    state_d = UNLOCKED;
                    good_d  = '0;
                    bad_d   = '0;
                end else begin
                    bad_d = bad_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= UNLOCKED;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            period_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt     <= good_d;
            bad_cnt      <= bad_d;
            period_valid <= cmp_req;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule
